control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Control-step FSM for the mini-RISC datapath; it is the issuing side of the register select/encode logic.
//  Fetches, decodes IR[31:27] and steps through T0..T7, driving Gra/Grb/Grc/Rin/Rout/BAout,
//  bus-source and latch enables, memory Read/Write, and the ALU op.
//  Sits between the top-level CPU wrapper and the datapath. Outputs are decoded from state, IR and con_ff.
// PARAMETERS
//  MEM_WAIT_MAX  16  cycles to wait for mem_done before asserting mem_err and forcing HALT_S
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high; forces RESET_S
//  IR           in   32  instruction register contents
//  con_ff       in   1   branch condition flop from datapath
//  mem_done     in   1   memory access complete (single-cycle pulse or level)
//  Gra,Grb,Grc  out  1   register field select to select/encode logic
//  Rin,Rout     out  1   general register in/out strobes
//  BAout        out  1   base-address out (R0 reads as 0)
//  Cout         out  1   sign-extended C onto bus
//  PCout,MDRout,Zhighout,Zlowout,HIout,LOout  out 1 each  bus sources
//  PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,CONin  out 1 each  latch enables
//  IncPC,Read,Write  out 1   PC increment, memory read/write strobes
//  alu_op       out  4   ALU function (cs_pkg encoding)
//  run          out  1   1 while executing; 0 in HALT_S
//  mem_err      out  1   sticky; set on memory timeout
// BEHAVIOUR
//  Reset: state=RESET_S; every output 0 except run=1; wait counter 0; mem_err cleared. RESET_S->T0 next clk.
//  Moore outputs: decoded combinationally from registered state and IR. Exactly one bus source active per step.
//  T0: PCout MARin IncPC Zin. T1: Zlowout PCin Read MDRin; hold T1 until mem_done.
//  T2: MDRout IRin. T3+ are per opcode, and the last step returns to T0.
//   ALU R (add..rol): T3 Grb Rout Yin | T4 Grc Rout alu_op Zin | T5 Zlowout Gra Rin.
//   ALU imm (addi/andi/ori): T3 Grb Rout Yin | T4 Cout alu_op Zin | T5 Zlowout Gra Rin.
//   ldi: T3 Grb BAout Yin | T4 Cout ADD Zin | T5 Zlowout Gra Rin.
//   ld: ldi T3/T4 | T5 Zlowout MARin | T6 Read MDRin, hold until mem_done | T7 MDRout Gra Rin.
//   st: ldi T3/T4 | T5 Zlowout MARin | T6 Gra Rout MDRin | T7 MDRout Write, hold until mem_done.
//   br: T3 Gra Rout CONin | T4 PCout Yin | T5 Cout ADD Zin | T6 Zlowout PCin only if con_ff=1.
//   jr: T3 Gra Rout PCin.  nop and undefined opcodes: go straight T2->T0.
//   halt: T2->HALT_S; run=0, all strobes 0; HALT_S exits only on reset.
//  Memory wait: counter increments each held cycle and clears on mem_done.
//   At MEM_WAIT_MAX: mem_err=1, go to HALT_S.
//   mem_done in the same cycle as the limit counts as success.
//  mem_done outside T1/T6/T7 waits is ignored.
//  Reset mid-instruction (including mid memory wait) aborts immediately and no strobe glitches to 1.
//  Gra/Grb/Grc never more than one high; Rin and Rout never both high.
// CONFIGURATION
//  MULDIV_EN defined: mul/div decode. T3 Gra Rout Yin | T4 Grb Rout alu_op(MUL/DIV) Zin | T5 Zlowout LOin | T6 Zhighout HIin.
//   mfhi/mflo: T3 HIout/LOout Gra Rin.
//  MULDIV_EN undefined: those opcodes decode as nop; HIin/LOin/HIout/LOout are tied 0.
// STRUCTURE
//  cs_pkg: opcode localparams (LD=00000 LDI=00001 ST=00010 ADD=00011 SUB=00100 AND=00101 OR=00110
//   SHR=00111 SHL=01000 ROR=01001 ROL=01010 ADDI=01011 ANDI=01100 ORI=01101 MUL=01110 DIV=01111
//   MFHI=10000 MFLO=10001 BR=10010 JR=10011 NOP=11010 HALT=11011), alu_op codes, state encoding
//   (RESET_S,T0..T7,HALT_S).
//  One sub-module, cs_mem_wait: wait counter plus timeout flag, shared by the T1/T6/T7 waits.
// TESTING
//  1 reset, then IR=0x18918000 (add R1,R2,R3), mem_done on 1st T1 cycle
//    -> T5 shows Zlowout=Gra=Rin=1, alu_op=ADD; T0 follows at cycle 7.
//  2 ld IR=0x00900010, mem_done delayed 3 cycles in T6
//    -> Read held 4 cycles; T7 MDRout Gra Rin; 11 cycles total.
//  3 br IR=0x90800000 with con_ff=0 then con_ff=1
//    -> PCin in T6 only in the second run.
//  4 halt IR=0xD8000000 -> run=0 from the cycle after T2 and stays 0 for 20 cycles; reset restores run=1.
//  5 mem_done never asserted in T1 -> mem_err=1 after MEM_WAIT_MAX=16 cycles, HALT_S entered.
//  6 reset asserted during ld T6 wait -> next edge sees all strobes 0 and RESET_S, then T0.
//    Undefined opcode 0xF8000000 returns T2->T0.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared definitions for the mini-RISC control sequencer: opcodes, ALU
// function codes, control-step encoding and instruction classification.
// Configuration macro: MULDIV_EN (enables mul/div/mfhi/mflo decode).
package cs_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function codes; ADD is zero so an idle alu_op reads as ADD.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;

    typedef enum logic [3:0] {
        RESET_S = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT_S = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP = 4'd0, CL_ALU_R = 4'd1, CL_ALU_I = 4'd2, CL_LDI = 4'd3,
        CL_LD = 4'd4, CL_ST = 4'd5, CL_BR = 4'd6, CL_JR = 4'd7,
        CL_HALT = 4'd8, CL_MULDIV = 4'd9, CL_MFHI = 4'd10, CL_MFLO = 4'd11
    } class_t;

    // Groups opcodes by the control-step sequence they follow.
    function automatic class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHL, OP_ROR, OP_ROL:             op_class = CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:           op_class = CL_ALU_I;
            OP_LDI:                             op_class = CL_LDI;
            OP_LD:                              op_class = CL_LD;
            OP_ST:                              op_class = CL_ST;
            OP_BR:                              op_class = CL_BR;
            OP_JR:                              op_class = CL_JR;
            OP_HALT:                            op_class = CL_HALT;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV:                     op_class = CL_MULDIV;
            OP_MFHI:                            op_class = CL_MFHI;
            OP_MFLO:                            op_class = CL_MFLO;
`endif
            default:                            op_class = CL_NOP;
        endcase
    endfunction

    // ALU function used by the step that loads Z for this opcode.
    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_SUB:          alu_of = ALU_SUB;
            OP_AND, OP_ANDI: alu_of = ALU_AND;
            OP_OR, OP_ORI:   alu_of = ALU_OR;
            OP_SHR:          alu_of = ALU_SHR;
            OP_SHL:          alu_of = ALU_SHL;
            OP_ROR:          alu_of = ALU_ROR;
            OP_ROL:          alu_of = ALU_ROL;
            OP_MUL:          alu_of = ALU_MUL;
            OP_DIV:          alu_of = ALU_DIV;
            default:         alu_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cs_mem_wait.sv
// Memory wait counter shared by the instruction fetch and load/store waits.
// 'timeout' fires in the MEM_WAIT_MAX-th consecutive held cycle when mem_done
// is still low; mem_done in that same cycle wins. mem_err is sticky until reset.
module cs_mem_wait #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_done,
    output logic timeout,
    output logic mem_err
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST_C = CW'(MEM_WAIT_MAX - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] count_r;
    logic          mem_err_r;

    assign timeout = waiting && !mem_done && (count_r == LAST_C);
    assign mem_err = mem_err_r;

    // Count held wait cycles; clear on completion, timeout or leaving the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= {CW{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            if (waiting && !mem_done && !timeout) begin
                count_r <= count_r + ONE_C;
            end else begin
                count_r <= {CW{1'b0}};
            end
            mem_err_r <= mem_err_r | timeout;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Control-step FSM for the mini-RISC datapath. Outputs are Moore-decoded from
// the registered step and IR (plus con_ff for the conditional branch load).
// IR is expected to present the fetched instruction by T2.
// Configuration macro: MULDIV_EN adds mul/div/mfhi/mflo sequences; when it is
// undefined those opcodes run as nop and HIin/LOin/HIout/LOout stay 0.
module control_sequencer
    import cs_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        con_ff,
    input  logic        mem_done,
    output logic        Gra, Grb, Grc,
    output logic        Rin, Rout, BAout, Cout,
    output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin,
    output logic        IncPC, Read, Write,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        mem_err
);
    state_t     state_r, next_s;
    class_t     cls_s;
    logic [4:0] opcode_s;
    logic [3:0] alu_code_s;
    logic       waiting_s, timeout_s;
    logic       unused_ir_s;

    assign opcode_s    = IR[31:27];
    assign cls_s       = op_class(opcode_s);
    assign alu_code_s  = alu_of(opcode_s);
    assign unused_ir_s = ^IR[26:0];
    assign waiting_s   = (state_r == T1) ||
                         ((state_r == T6) && (cls_s == CL_LD)) ||
                         ((state_r == T7) && (cls_s == CL_ST));

    cs_mem_wait #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_mem_wait (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting_s),
        .mem_done (mem_done),
        .timeout  (timeout_s),
        .mem_err  (mem_err)
    );

    // Control-step register; reset aborts any instruction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RESET_S;
        end else begin
            state_r <= next_s;
        end
    end

    // Next control step from the current step, instruction class and memory handshake.
    always_comb begin
        next_s = state_r;
        case (state_r)
            RESET_S: next_s = T0;
            T0:      next_s = T1;
            T1: begin
                if (mem_done)       next_s = T2;
                else if (timeout_s) next_s = HALT_S;
                else                next_s = T1;
            end
            T2: begin
                case (cls_s)
                    CL_HALT: next_s = HALT_S;
                    CL_NOP:  next_s = T0;
                    default: next_s = T3;
                endcase
            end
            T3: begin
                if (cls_s == CL_JR || cls_s == CL_MFHI || cls_s == CL_MFLO) next_s = T0;
                else                                                        next_s = T4;
            end
            T4: next_s = T5;
            T5: begin
                case (cls_s)
                    CL_LD, CL_ST, CL_BR, CL_MULDIV: next_s = T6;
                    default:                        next_s = T0;
                endcase
            end
            T6: begin
                case (cls_s)
                    CL_LD: begin
                        if (mem_done)       next_s = T7;
                        else if (timeout_s) next_s = HALT_S;
                        else                next_s = T6;
                    end
                    CL_ST:   next_s = T7;
                    default: next_s = T0;
                endcase
            end
            T7: begin
                if (cls_s == CL_ST) begin
                    if (mem_done)       next_s = T0;
                    else if (timeout_s) next_s = HALT_S;
                    else                next_s = T7;
                end else begin
                    next_s = T0;
                end
            end
            HALT_S:  next_s = HALT_S;
            default: next_s = RESET_S;
        endcase
    end

    // Strobe decode: everything idle by default, one bus source per step.
    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout}                   = 7'b0;
        {PCout, MDRout, Zhighout, Zlowout, HIout, LOout}          = 6'b0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin}   = 9'b0;
        {IncPC, Read, Write}                                      = 3'b0;
        alu_op = ALU_ADD;
        run    = 1'b1;
        case (state_r)
            RESET_S: run = 1'b1;
            T0: {PCout, MARin, IncPC, Zin}  = 4'b1111;
            T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
            T2: {MDRout, IRin}               = 2'b11;
            T3: begin
                case (cls_s)
                    CL_ALU_R, CL_ALU_I:  {Grb, Rout, Yin}   = 3'b111;
                    CL_LDI, CL_LD, CL_ST: {Grb, BAout, Yin} = 3'b111;
                    CL_BR:               {Gra, Rout, CONin} = 3'b111;
                    CL_JR:               {Gra, Rout, PCin}  = 3'b111;
`ifdef MULDIV_EN
                    CL_MULDIV:           {Gra, Rout, Yin}   = 3'b111;
                    CL_MFHI:             {HIout, Gra, Rin}  = 3'b111;
                    CL_MFLO:             {LOout, Gra, Rin}  = 3'b111;
`endif
                    default:             run = 1'b1;
                endcase
            end
            T4: begin
                case (cls_s)
                    CL_ALU_R: begin
                        {Grc, Rout, Zin} = 3'b111;
                        alu_op = alu_code_s;
                    end
                    CL_ALU_I, CL_LDI, CL_LD, CL_ST: begin
                        {Cout, Zin} = 2'b11;
                        alu_op = alu_code_s;
                    end
                    CL_BR: {PCout, Yin} = 2'b11;
`ifdef MULDIV_EN
                    CL_MULDIV: begin
                        {Grb, Rout, Zin} = 3'b111;
                        alu_op = alu_code_s;
                    end
`endif
                    default: run = 1'b1;
                endcase
            end
            T5: begin
                case (cls_s)
                    CL_ALU_R, CL_ALU_I, CL_LDI: {Zlowout, Gra, Rin} = 3'b111;
                    CL_LD, CL_ST:               {Zlowout, MARin}    = 2'b11;
                    CL_BR: begin
                        {Cout, Zin} = 2'b11;
                        alu_op = ALU_ADD;
                    end
`ifdef MULDIV_EN
                    CL_MULDIV: {Zlowout, LOin} = 2'b11;
`endif
                    default: run = 1'b1;
                endcase
            end
            T6: begin
                case (cls_s)
                    CL_LD: {Read, MDRin}       = 2'b11;
                    CL_ST: {Gra, Rout, MDRin}  = 3'b111;
                    CL_BR: begin
                        Zlowout = 1'b1;
                        PCin    = con_ff;
                    end
`ifdef MULDIV_EN
                    CL_MULDIV: {Zhighout, HIin} = 2'b11;
`endif
                    default: run = 1'b1;
                endcase
            end
            T7: begin
                case (cls_s)
                    CL_LD:   {MDRout, Gra, Rin} = 3'b111;
                    CL_ST:   {MDRout, Write}    = 2'b11;
                    default: run = 1'b1;
                endcase
            end
            HALT_S:  run = 1'b0;
            default: run = 1'b0;
        endcase
    end

endmodule
